// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register family.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W_DEF = 64;
  localparam int unsigned PIPE_CTRL_W_DEF = 8;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus payload register.
// Priority is reset, then clear, then load. Clear keeps the payload so a drained stage still shows its last data.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, flush and bubble-masked control bits.
// Define PIPE_STAGE_SKID_EN for the two-slot skid build with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W_DEF,
  parameter int unsigned CTRL_W = PIPE_CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output occ_t              occ
);

  if (CTRL_W > DATA_W || DATA_W == 0) begin : g_bad_cfg
    $error("pipe_stage_reg: CTRL_W must not exceed DATA_W and DATA_W must be nonzero");
  end

  localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

  logic              accept;
  logic              deliver;
  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;

  assign accept    = in_valid && in_ready;
  assign deliver   = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_q : (main_q & ~CTRL_MASK);

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] skid_q;

  assign in_ready = !skid_valid;
  assign occ      = occ_t'({1'b0, main_valid}) + occ_t'({1'b0, skid_valid});

  // Skid is only ever occupied while main is, so main refills from skid first.
  always_comb begin
    main_d     = skid_valid ? skid_q : in_data;
    main_load  = (!main_valid && accept) || (deliver && (skid_valid || accept));
    main_clear = flush || (deliver && !skid_valid && !accept);
    skid_load  = main_valid && !deliver && accept;
    skid_clear = flush || (deliver && skid_valid);
  end

  pipe_slot #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_data),
    .valid (skid_valid),
    .q     (skid_q)
  );
`else
  assign in_ready = out_ready || !main_valid;
  assign occ      = occ_t'({1'b0, main_valid});

  always_comb begin
    main_d     = in_data;
    main_load  = accept;
    main_clear = flush || (deliver && !accept);
  end
`endif

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DATA_W=16, CTRL_W=4) against a FIFO-queue reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stage contents as an ordered queue of beats, plus last payload shown.
  logic [15:0] mq[$];
  logic [15:0] last_main = '0;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  function automatic logic exp_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return out_ready || (mq.size() == 0);
`endif
  endfunction

  function automatic logic [15:0] exp_out_data();
    if (mq.size() > 0) return mq[0];
    return last_main & 16'hFFF0;
  endfunction

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [15:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    logic acc, del;
    acc = in_valid && exp_in_ready();
    del = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      last_main = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
    end
    if (mq.size() > 0) last_main = mq[0];
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 16'hABCD, 1'($urandom));
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [15:0] beats [0:4];
    beats = '{16'h0011, 16'h0022, 16'h0033, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, (i < 3), beats[i], 1'b1);
      if (i > 0) begin
        n_cmp++; if (out_valid !== (i < 4)) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want %b", i, out_valid, (i < 4)); end
        n_cmp++; if (out_data !== exp_out_data()) begin n_bad++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, exp_out_data()); end
        if (i < 4) begin
          n_cmp++; if (out_data !== beats[i-1]) begin n_bad++; $display("FAIL stream_order[%0d] got %h want %h", i, out_data, beats[i-1]); end
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      end
      tick();
    end
  endtask

  task automatic test_skid();
    logic [15:0] d [0:5];
    logic        iv [0:5];
    logic        ordy [0:5];
    d    = '{16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    iv   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ordy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, iv[i], d[i], ordy[i]);
      n_cmp++; if (occ !== 2'(mq.size())) begin n_bad++; $display("FAIL skid_occ[%0d] got %0d want %0d", i, occ, mq.size()); end
      n_cmp++; if (in_ready !== exp_in_ready()) begin n_bad++; $display("FAIL skid_in_ready[%0d] got %b want %b", i, in_ready, exp_in_ready()); end
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL skid_valid[%0d] got %b want %b", i, out_valid, (mq.size() > 0)); end
      n_cmp++; if (out_data !== exp_out_data()) begin n_bad++; $display("FAIL skid_data[%0d] got %h want %h", i, out_data, exp_out_data()); end
      if (i == 2) begin
        n_cmp++; if (occ !== 2'(CAP)) begin n_bad++; $display("FAIL skid_full_occ got %0d want %0d", occ, CAP); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_full_in_ready got %b want 0", in_ready); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1'b0, 1'b0, 1'b1, 16'h4444, 1'b0);
        1: drive(1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        2: drive(1'b0, 1'b1, 1'b1, 16'h3333, 1'b0);
        default: drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      endcase
      n_cmp++; if (occ !== 2'(mq.size())) begin n_bad++; $display("FAIL flush_occ[%0d] got %0d want %0d", i, occ, mq.size()); end
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL flush_valid[%0d] got %b want %b", i, out_valid, (mq.size() > 0)); end
      n_cmp++; if (out_data !== exp_out_data()) begin n_bad++; $display("FAIL flush_data[%0d] got %h want %h", i, out_data, exp_out_data()); end
      if (i >= 3) begin
        n_cmp++; if (out_data[3:0] !== 4'h0) begin n_bad++; $display("FAIL flush_ctrl_mask[%0d] got %h want 0", i, out_data[3:0]); end
        n_cmp++; if (out_data === 16'h3333) begin n_bad++; $display("FAIL flush_discard[%0d] got %h want not 3333", i, out_data); end
      end
      tick();
    end
  endtask

  task automatic test_flush_rst();
    drive(1'b0, 1'b0, 1'b1, 16'h6789, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstflush_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL rstflush_data got %h want 0000", out_data); end
    n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL rstflush_occ got %0d want 0", occ); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstflush_in_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 14) == 0),
            1'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL rand_valid[%0d] got %b want %b", i, out_valid, (mq.size() > 0)); end
      n_cmp++; if (out_data !== exp_out_data()) begin n_bad++; $display("FAIL rand_data[%0d] got %h want %h", i, out_data, exp_out_data()); end
      n_cmp++; if (in_ready !== exp_in_ready()) begin n_bad++; $display("FAIL rand_in_ready[%0d] got %b want %b", i, in_ready, exp_in_ready()); end
      n_cmp++; if (occ !== 2'(mq.size()) || occ > 2'(CAP)) begin n_bad++; $display("FAIL rand_occ[%0d] got %0d want %0d", i, occ, mq.size()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_flush_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
